mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory-side stage directly downstream of the multicycle control unit. Turns its
//  level MemRead/MemWrite/IRWrite/IorD strobes into a req/ack transaction on the
//  shared instruction/data memory, and owns the Instruction Register (IR, which
//  drives opCode back to the control unit) and the Memory Data Register (MDR).
//  Asserts mem_busy so the control unit holds its state until the access completes.
// PARAMETERS
//  ADDR_W          32  byte-address width of pc, alu_out and mem_addr
//  DATA_W          32  word width of memory data, IR and MDR
//  TIMEOUT_CYCLES  16  max REQ cycles without mem_ack before a bus error (>=1)
// PORTS
//  clk         in   1       system clock, all state updates on rising edge
//  reset       in   1       synchronous, active-high
//  MemRead     in   1       from control unit: read request (level)
//  MemWrite    in   1       from control unit: write request (level)
//  IRWrite     in   1       from control unit: read data goes to IR (else MDR)
//  IorD        in   1       0: address = pc, 1: address = alu_out
//  pc          in   ADDR_W  current program counter
//  alu_out     in   ADDR_W  ALUOut register (load/store effective address)
//  write_data  in   DATA_W  register-file B value for stores
//  mem_req     out  1       memory request, held until mem_ack or timeout
//  mem_we      out  1       1 = write transaction
//  mem_addr    out  ADDR_W  latched byte address
//  mem_wdata   out  DATA_W  latched store data
//  mem_rdata   in   DATA_W  read data, valid when mem_ack=1
//  mem_ack     in   1       one-cycle completion from memory
//  instr       out  DATA_W  Instruction Register
//  opCode      out  6       instr[31:26], to control unit
//  mdr         out  DATA_W  Memory Data Register
//  mem_busy    out  1       access in progress; control unit must stall
//  bus_error   out  1       sticky: a request timed out
//  misaligned  out  1       sticky: access with address[1:0] != 0
// BEHAVIOUR
//  Reset: state=IDLE; mem_req, mem_we, mem_busy, bus_error, misaligned = 0;
//   mem_addr, mem_wdata, instr, mdr = 0; timeout counter = 0.
//  FSM IDLE -> REQ -> DONE -> IDLE:
//   IDLE: if MemRead|MemWrite: mem_busy=1 (combinational, same cycle); latch
//    addr = IorD ? alu_out : pc, we = MemWrite, wdata = write_data, dest = IRWrite.
//    MemWrite wins if both asserted. addr[1:0]!=0 -> set misaligned, go DONE,
//    no request issued, IR/MDR unchanged. Else go REQ.
//   REQ: mem_req=1, mem_busy=1, mem_addr/mem_we/mem_wdata stable. mem_ack=1 ->
//    if read: mem_rdata into instr (dest=1) or mdr (dest=0); go DONE. Counter
//    increments each REQ cycle without ack; on reaching TIMEOUT_CYCLES set
//    bus_error, drop mem_req, go DONE, no IR/MDR update. Counter clears on exit.
//   DONE: mem_busy=0, mem_req=0; unconditionally go IDLE (no re-trigger on the
//    still-asserted strobes of the cycle the control unit leaves its state).
//  Latency: ack in first REQ cycle -> strobe seen cycle 0, req cycle 1, IR/MDR
//   valid and busy=0 cycle 2; each extra wait cycle adds 1.
//  mem_ack outside REQ is ignored. Writes never modify IR/MDR.
//  Reset mid-transaction: mem_req low after the reset edge, state IDLE; a late
//   mem_ack is ignored. Sticky flags clear only on reset.
// TESTING
//  Fetch: pc=0x40, MemRead=IRWrite=1, ack 1st REQ cycle, rdata=0x2008_0005 ->
//   mem_addr=0x40, instr=0x2008_0005, opCode=6'b001000, busy low in cycle 2.
//  Load: IorD=1, alu_out=0x100, ack after 3 wait cycles, rdata=0xDEAD_BEEF ->
//   mdr=0xDEAD_BEEF, instr unchanged, busy high exactly 5 cycles (IDLE+4 REQ).
//  Store: MemWrite=1, alu_out=0x204, write_data=0x1234 -> mem_we=1,
//   mem_wdata=0x1234 held until ack; IR/MDR unchanged.
//  Timeout: MemRead, no ack for 16 REQ cycles -> mem_req drops, bus_error=1
//   sticky, instr unchanged; next fetch proceeds normally.
//  Misaligned: IorD=1, alu_out=0x102 -> no mem_req ever, misaligned=1, DONE next.
//  Reset in REQ, ack on following cycle -> mem_req=0, instr/mdr=0, ack ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory access stage behind the multicycle control unit: converts level strobes into a
// req/ack memory transaction, owns the IR and MDR, and stalls the control unit via mem_busy.
module mem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IRWrite,
  input  logic              IorD,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] write_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        opCode,
  output logic [DATA_W-1:0] mdr,
  output logic              mem_busy,
  output logic              bus_error,
  output logic              misaligned
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  timeout_cnt;
  logic              dest_ir;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              start_misaligned;
  logic              timeout_hit;

  assign start            = MemRead | MemWrite;
  assign start_addr       = IorD ? alu_out : pc;
  assign start_misaligned = (start_addr[1:0] != 2'b00);
  // The counter holds the number of REQ cycles already spent waiting, so the
  // last permitted cycle is TIMEOUT_CYCLES-1.
  assign timeout_hit      = !mem_ack && (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign opCode           = instr[31:26];

  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: the default assignment first keeps this combinational block free
  // of inferred latches on any path the case does not cover.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = start_misaligned ? DONE : REQ;
      REQ:  if (mem_ack || timeout_hit) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req  = (state == REQ);
    mem_busy = (state == REQ) || ((state == IDLE) && start);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      dest_ir     <= 1'b0;
      instr       <= '0;
      mdr         <= '0;
      timeout_cnt <= '0;
      bus_error   <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mem_addr  <= start_addr;
            mem_we    <= MemWrite;
            mem_wdata <= write_data;
            dest_ir   <= IRWrite;
            if (start_misaligned) misaligned <= 1'b1;
          end
        end
        REQ: begin
          if (mem_ack) begin
            timeout_cnt <= '0;
            if (!mem_we) begin
              if (dest_ir) instr <= mem_rdata;
              else         mdr   <= mem_rdata;
            end
          end else if (timeout_hit) begin
            timeout_cnt <= '0;
            bus_error   <= 1'b1;
          end else begin
            timeout_cnt <= timeout_cnt + CNT_W'(1);
          end
        end
        default: timeout_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a control-unit driver queues expected requests and
// completions, a memory responder checks each request, and a monitor checks each completion.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, IRWrite, IorD;
  logic [31:0] pc, alu_out, write_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [31:0] instr, mdr;
  logic [5:0]  opCode;
  logic        mem_busy, bus_error, misaligned;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .IorD(IorD),
    .pc(pc), .alu_out(alu_out), .write_data(write_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .instr(instr), .opCode(opCode), .mdr(mdr),
    .mem_busy(mem_busy), .bus_error(bus_error), .misaligned(misaligned)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] mdr;
    logic        berr;
    logic        mis;
    int          busy;
  } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: acks after ack_wait extra REQ cycles (negative = never).
  int          ack_wait = 0;
  logic [31:0] rd_value = '0;
  bit          resp_en  = 1'b1;
  logic        resp_ack = 1'b0;
  logic [31:0] resp_rdata = '0;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = '0;
  bit          in_flight = 1'b0;
  int          wait_cnt = 0;
  req_t        cur_req;

  assign mem_ack   = resp_ack | man_ack;
  assign mem_rdata = man_ack ? man_rdata : resp_rdata;

  always @(negedge clk) begin
    if (resp_en && !reset) begin
      if (mem_req) begin
        if (!in_flight) begin
          in_flight = 1'b1;
          wait_cnt  = 0;
          if (req_q.size() == 0) begin
            check("unexpected_req", {63'd0, mem_req}, 64'd0);
            cur_req = '{addr: mem_addr, we: mem_we, wdata: mem_wdata};
          end else begin
            cur_req = req_q.pop_front();
          end
        end
        check("mem_addr",  {32'd0, mem_addr},  {32'd0, cur_req.addr});
        check("mem_we",    {63'd0, mem_we},    {63'd0, cur_req.we});
        check("mem_wdata", {32'd0, mem_wdata}, {32'd0, cur_req.wdata});
        if (ack_wait >= 0 && wait_cnt == ack_wait) begin
          resp_ack   = 1'b1;
          resp_rdata = rd_value;
        end else begin
          resp_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        resp_ack  = 1'b0;
        in_flight = 1'b0;
      end
    end else begin
      resp_ack  = 1'b0;
      in_flight = 1'b0;
    end
  end

  // Completion monitor: a busy falling edge marks the end of an access.
  int busy_cnt  = 0;
  bit prev_busy = 1'b0;
  resp_t e;

  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else if (mem_busy) begin
      busy_cnt++;
      prev_busy = 1'b1;
    end else if (prev_busy) begin
      prev_busy = 1'b0;
      if (resp_q.size() == 0) begin
        check("unexpected_done", {32'd0, resp_q.size()}, 64'd1);
      end else begin
        e = resp_q.pop_front();
        check("instr",      {32'd0, instr},      {32'd0, e.instr});
        check("opCode",     {58'd0, opCode},     {58'd0, e.instr[31:26]});
        check("mdr",        {32'd0, mdr},        {32'd0, e.mdr});
        check("bus_error",  {63'd0, bus_error},  {63'd0, e.berr});
        check("misaligned", {63'd0, misaligned}, {63'd0, e.mis});
        check("busy_cycles", 64'(busy_cnt),      64'(e.busy));
      end
      busy_cnt = 0;
    end
  end

  task automatic do_access(input bit rd, input bit wr, input bit irw, input bit iord,
                           input logic [31:0] pc_v, input logic [31:0] alu_v,
                           input logic [31:0] wd_v, input int aw, input logic [31:0] rdv,
                           input bit exp_req, input resp_t exp);
    bit done = 1'b0;
    ack_wait = aw;
    rd_value = rdv;
    if (exp_req) req_q.push_back('{addr: (iord ? alu_v : pc_v), we: wr, wdata: wd_v});
    resp_q.push_back(exp);
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; IRWrite = irw; IorD = iord;
    pc = pc_v; alu_out = alu_v; write_data = wd_v;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!mem_busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("busy_release_timeout", {63'd0, mem_busy}, 64'd0);
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0; IorD = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen_req;
    reset = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0; IorD = 1'b0;
    pc = '0; alu_out = '0; write_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mem_req",    {63'd0, mem_req},    64'd0);
    check("rst_mem_we",     {63'd0, mem_we},     64'd0);
    check("rst_mem_busy",   {63'd0, mem_busy},   64'd0);
    check("rst_bus_error",  {63'd0, bus_error},  64'd0);
    check("rst_misaligned", {63'd0, misaligned}, 64'd0);
    check("rst_mem_addr",   {32'd0, mem_addr},   64'd0);
    check("rst_mem_wdata",  {32'd0, mem_wdata},  64'd0);
    check("rst_instr",      {32'd0, instr},      64'd0);
    check("rst_mdr",        {32'd0, mdr},        64'd0);

    // Fetch, ack in first REQ cycle.
    do_access(1, 0, 1, 0, 32'h40, 32'h0, 32'h0, 0, 32'h2008_0005, 1,
              '{instr: 32'h2008_0005, mdr: 32'h0, berr: 0, mis: 0, busy: 2});
    // Load, three wait cycles.
    do_access(1, 0, 0, 1, 32'h44, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, 1,
              '{instr: 32'h2008_0005, mdr: 32'hDEAD_BEEF, berr: 0, mis: 0, busy: 5});
    // Store, two wait cycles; read data offered must be ignored.
    do_access(0, 1, 0, 1, 32'h48, 32'h204, 32'h1234, 2, 32'h5555_AAAA, 1,
              '{instr: 32'h2008_0005, mdr: 32'hDEAD_BEEF, berr: 0, mis: 0, busy: 4});
    // Read and write together: the write wins, IR untouched.
    do_access(1, 1, 1, 1, 32'h48, 32'h208, 32'hCAFE_0001, 0, 32'hBAD0_BAD0, 1,
              '{instr: 32'h2008_0005, mdr: 32'hDEAD_BEEF, berr: 0, mis: 0, busy: 2});
    // Timeout: 16 REQ cycles with no ack.
    do_access(1, 0, 1, 0, 32'h48, 32'h0, 32'h0, -1, 32'h0, 1,
              '{instr: 32'h2008_0005, mdr: 32'hDEAD_BEEF, berr: 1, mis: 0, busy: 17});
    // Fetch after timeout, one wait cycle; bus_error stays set.
    do_access(1, 0, 1, 0, 32'h4C, 32'h0, 32'h0, 1, 32'h8C09_0004, 1,
              '{instr: 32'h8C09_0004, mdr: 32'hDEAD_BEEF, berr: 1, mis: 0, busy: 3});
    // Misaligned load: no request, DONE on the next cycle.
    do_access(1, 0, 0, 1, 32'h50, 32'h102, 32'h0, 0, 32'h1111_1111, 0,
              '{instr: 32'h8C09_0004, mdr: 32'hDEAD_BEEF, berr: 1, mis: 1, busy: 1});

    // Reset while in REQ, then a late ack that must be ignored.
    resp_en = 1'b0;
    @(posedge clk); #1;
    MemRead = 1'b1; IRWrite = 1'b1; IorD = 1'b0; pc = 32'h60;
    seen_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req) begin
        seen_req = 1'b1;
        break;
      end
    end
    check("reset_test_req_seen", {63'd0, mem_req}, 64'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    MemRead = 1'b0; IRWrite = 1'b0;
    man_ack = 1'b1; man_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("rst_mid_mem_req",  {63'd0, mem_req},  64'd0);
    check("rst_mid_mem_busy", {63'd0, mem_busy}, 64'd0);
    @(posedge clk); #1 man_ack = 1'b0;
    @(negedge clk);
    check("rst_mid_instr",      {32'd0, instr},      64'd0);
    check("rst_mid_mdr",        {32'd0, mdr},        64'd0);
    check("rst_mid_mem_req2",   {63'd0, mem_req},    64'd0);
    check("rst_mid_bus_error",  {63'd0, bus_error},  64'd0);
    check("rst_mid_misaligned", {63'd0, misaligned}, 64'd0);
    resp_en = 1'b1;

    // Normal fetch after reset.
    do_access(1, 0, 1, 0, 32'h54, 32'h0, 32'h0, 0, 32'h0000_0020, 1,
              '{instr: 32'h0000_0020, mdr: 32'h0, berr: 0, mis: 0, busy: 2});

    repeat (3) @(negedge clk);
    check("req_q_drained",  64'(req_q.size()),  64'd0);
    check("resp_q_drained", 64'(resp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
